serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: adds two operands LSB-first using one full_a full-adder cell and a carry flip-flop.
- Sits directly around the existing full_a cell. It feeds full_a one bit pair plus carry per clock and consumes its S/Cout outputs into a sum shift register.
- Trades the area of N full adders for WIDTH cycles of latency.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- S  output  WIDTH  sum (A+B+Cin) mod 2^WIDTH; registered.
- Cout  output  1  carry out of the MSB; registered.
- busy  output  1  high while the addition is in progress.
- done  output  1  one-cycle pulse: S/Cout valid.

Behaviour:
- Clock and reset (fixed): single clock clk; reset is synchronous and active-low on rst_n.
- Reset, sampled on a rising edge with rst_n=0:
  - state=IDLE.
  - A/B shift registers, sum register, carry flop and bit counter all = 0.
  - Outputs: S=0, Cout=0, busy=0, done=0.
  - Applies in any state and aborts an in-flight addition with no partial result.
- States: IDLE, SHIFT, DONE (binary encoded).
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load A_reg<=A, B_reg<=B, carry<=Cin, count<=0, sum_reg<=0; go to SHIFT.
- SHIFT (busy=1), on each edge:
  - full_a inputs are A_reg[0], B_reg[0] and carry.
  - sum_reg <= {full_a.S, sum_reg[WIDTH-1:1]}.
  - carry <= full_a.Cout.
  - A_reg and B_reg shift right by one, filling with zeros.
  - count <= count+1.
  - When count==WIDTH-1, this edge is the last shift and the FSM goes to DONE.
  - Exactly WIDTH edges are spent in SHIFT.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Output holding:
  - S mirrors sum_reg and Cout mirrors carry.
  - Both hold stable from DONE until the next accepted start, when they clear.
- Latency:
  - Start accepted at edge 0.
  - Result registered at edge WIDTH; done high in the cycle after edge WIDTH.
  - Next start can be accepted at edge WIDTH+2.
- start is ignored in SHIFT and DONE; there is no queuing.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic: {Cout,S} == A+B+Cin, exact, WIDTH+1 bits. Overflow is reported only via Cout.
- WIDTH=1: one SHIFT cycle; behaves as a registered full_a.
- Counter width: $clog2(WIDTH), minimum 1 bit.
- Simultaneous rst_n=0 and start=1: reset wins.

Decomposition:
- Shared include file (serial_defs.vh):
  - State encoding localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width macro.
- One sub-module, instantiated once: full_a, the existing full-adder cell (ports A, B, Cin, S, Cout).
- No other hierarchy.

Test Plan (WIDTH=8 unless stated):
1. Reset, then start with A=8'h00, B=8'h00, Cin=0 -> busy high for 8 cycles; done pulses exactly 1 cycle after edge 8; S=8'h00, Cout=0.
2. A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1; S/Cout stay stable for 5 idle cycles after done.
3. A=8'hA5, B=8'h5A, Cin=1 -> S=8'h00, Cout=1 (full carry ripple through every bit).
4. Start A=8'h12, B=8'h34, Cin=0; on cycle 3 pulse start with A=8'hFF, B=8'hFF -> second request ignored; S=8'h46, Cout=0, single done pulse.
5. Drop rst_n for one edge mid-SHIFT (cycle 4) -> next cycle busy=0, done=0, S=0, Cout=0, no done pulse. Then A=8'h7F, B=8'h01 -> S=8'h80, Cout=0.
6. WIDTH=1, all 8 {A,B,Cin} combinations -> {Cout,S} matches the full-adder truth table (000->00, 001->01, 011->10, 111->11, ...), done 2 edges after start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_a.sv
// Single-bit full-adder cell used by the serial adder datapath.
module full_a (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_a cell plus a carry flop adds A+B+Cin LSB-first over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             fa_s;
  logic             fa_cout;

  full_a u_full_a (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry_reg),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lines up with the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign sum_next[gi] = fa_s;
      end else begin : g_lower
        assign sum_next[gi] = sum_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            count_reg <= '0;
            sum_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          sum_reg   <= sum_next;
          carry_reg <= fa_cout;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign S    = sum_reg;
  assign Cout = carry_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random vectors against A+B+Cin.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic [7:0] s;
  logic       cout, busy, done;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       s1, cout1, busy1, done1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
    .S(s), .Cout(cout), .busy(busy), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .busy(busy1), .done(done1)
  );

  // Issues one request on the 8-bit DUT and waits (bounded) for done; lat=1 is the sample after the accepting edge.
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      output logic [8:0] res, output int lat);
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {cout, s};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({s, cout, busy, done} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: S=%h Cout=%b busy=%b done=%b, required all zero", s, cout, busy, done);
    end
    vectors++;
    if ({s1, cout1, busy1, done1} !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_w1: S=%b Cout=%b busy=%b done=%b, required all zero", s1, cout1, busy1, done1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: S=%h Cout=%b busy=%b done=%b", s, cout, busy, done);
  endtask

  task automatic test_zero_timing();
    int busy_cycles = 0;
    @(negedge clk);
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cycles++;
      if (i < 7) @(negedge clk);
    end
    vectors++;
    if (busy_cycles != 8) begin
      miscompares++;
      $display("FAIL zero_busy: busy-only cycles=%0d, required 8", busy_cycles);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || {cout, s} !== 9'h000) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b {Cout,S}=%h, required 1 0 000", done, busy, {cout, s});
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulse: done=%b one cycle later, required 0", done);
    end
    $display("zero: 00+00+0 -> {Cout,S}=%h busy_cycles=%0d", {cout, s}, busy_cycles);
  endtask

  task automatic test_overflow_hold();
    logic [8:0] res;
    int lat;
    int unstable = 0;
    run8(8'hFF, 8'h01, 1'b0, res, lat);
    vectors++;
    if (res !== 9'h100 || lat != 9) begin
      miscompares++;
      $display("FAIL overflow: {Cout,S}=%h lat=%0d, required 100 lat=9", res, lat);
    end
    repeat (5) begin
      @(negedge clk);
      if ({cout, s} !== 9'h100) unstable++;
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL hold: %0d idle cycles changed result, required 0", unstable);
    end
    $display("overflow: FF+01+0 -> {Cout,S}=%h lat=%0d", res, lat);
  endtask

  task automatic test_ripple();
    logic [8:0] res;
    int lat;
    run8(8'hA5, 8'h5A, 1'b1, res, lat);
    vectors++;
    if (res !== 9'h100 || lat != 9) begin
      miscompares++;
      $display("FAIL ripple: {Cout,S}=%h lat=%0d, required 100 lat=9", res, lat);
    end
    $display("ripple: A5+5A+1 -> {Cout,S}=%h", res);
  endtask

  task automatic test_ignored_start();
    int pulses = 0;
    logic [8:0] res = '0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        a = 8'hFF; b = 8'hFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        res = {cout, s};
      end
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (pulses != 1 || res !== 9'h046) begin
      miscompares++;
      $display("FAIL ignored_start: pulses=%0d {Cout,S}=%h, required 1 046", pulses, res);
    end
    $display("ignored_start: 12+34 with stray start -> {Cout,S}=%h pulses=%0d", res, pulses);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    logic [8:0] res;
    int lat;
    @(negedge clk);
    a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({s, cout, busy, done} !== 11'd0) begin
      miscompares++;
      $display("FAIL abort: S=%h Cout=%b busy=%b done=%b, required all zero", s, cout, busy, done);
    end
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: %0d busy/done cycles after abort, required 0", pulses);
    end
    run8(8'h7F, 8'h01, 1'b0, res, lat);
    vectors++;
    if (res !== 9'h080 || lat != 9) begin
      miscompares++;
      $display("FAIL after_abort: {Cout,S}=%h lat=%0d, required 080 lat=9", res, lat);
    end
    $display("reset_abort: then 7F+01+0 -> {Cout,S}=%h", res);
  endtask

  task automatic test_random();
    logic [8:0] res;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic       rc;
    int lat;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, res, lat);
      vectors++;
      if (res !== exp || lat != 9) begin
        miscompares++;
        $display("FAIL random: %h+%h+%b -> {Cout,S}=%h lat=%0d, required %h lat=9", ra, rb, rc, res, lat, exp);
      end else begin
        $display("random: %h+%h+%b -> {Cout,S}=%h", ra, rb, rc, res);
      end
    end
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    logic [2:0] v;
    int lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      lat = 1;
      while (done1 !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      vectors++;
      if ({cout1, s1} !== exp || lat != 2) begin
        miscompares++;
        $display("FAIL width1: ABC=%b -> {Cout,S}=%b lat=%0d, required %b lat=2", v, {cout1, s1}, lat, exp);
      end else begin
        $display("width1: ABC=%b -> {Cout,S}=%b", v, {cout1, s1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_timing();
    test_overflow_hold();
    test_ripple();
    test_ignored_start();
    test_reset_abort();
    test_random();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
